// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline load/store request into one or two
// word-wide data-memory accesses (split when the access crosses a word),
// then returns a single-cycle response with the extended load data or an
// error flag for illegal encodings and out-of-range addresses.
module load_store_unit #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FIRST  = 3'd1,
      SECOND = 3'd2,
      WAIT   = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t state_r, next_state_s;

   // request decode (only meaningful while IDLE)
   logic [1:0]            off_s;
   logic [3:0]            mask_s;
   logic [DATA_W-1:0]     wdata_s;
   logic [32:0]           last_s;
   logic                  f3_ok_s;
   logic                  err_s;
   logic [7:0]            be8_s;
   logic [2*DATA_W-1:0]   wd64_s;
   logic                  split_s;
   logic [DM_ADDRESS-1:0] addr_lo_s;
   logic [DM_ADDRESS-1:0] addr_hi_s;
   logic                  accept_s;

   // request fields latched at acceptance
   logic                  we_r;
   logic [2:0]            funct3_r;
   logic [1:0]            off_r;
   logic                  split_r;
   logic [DM_ADDRESS-1:0] addr_hi_r;
   logic [3:0]            be_hi_r;
   logic [DATA_W-1:0]     wd_hi_r;
   logic [DATA_W-1:0]     lo_r;

   // load extraction and next-cycle output values
   logic [2*DATA_W-1:0]   rd64_s;
   logic [DATA_W-1:0]     sh_s;
   logic [DATA_W-1:0]     ext_s;
   logic                  mem_re_n_s, mem_we_n_s, resp_valid_n_s, resp_err_n_s;
   logic [DM_ADDRESS-1:0] mem_addr_n_s;
   logic [3:0]            mem_be_n_s;
   logic [DATA_W-1:0]     mem_wd_n_s, resp_rdata_n_s;

   assign accept_s  = req_valid && (state_r == IDLE);
   assign req_ready = (state_r == IDLE) && !reset;

   // decode size, legality, byte lanes and split condition of the incoming request
   always_comb begin
      off_s   = req_addr[1:0];
      mask_s  = 4'b0000;
      wdata_s = {DATA_W{1'b0}};
      last_s  = {1'b0, req_addr};
      case (req_funct3[1:0])
         2'b00: begin
            mask_s  = 4'b0001;
            wdata_s = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
         end
         2'b01: begin
            mask_s  = 4'b0011;
            wdata_s = {{(DATA_W-16){1'b0}}, req_wdata[15:0]};
            last_s  = {1'b0, req_addr} + 33'd1;
         end
         2'b10: begin
            mask_s  = 4'b1111;
            wdata_s = req_wdata;
            last_s  = {1'b0, req_addr} + 33'd3;
         end
         default: begin
            mask_s  = 4'b0000;
            wdata_s = {DATA_W{1'b0}};
         end
      endcase
      if (req_we) begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok_s = 1'b1;
            default:                f3_ok_s = 1'b0;
         endcase
      end else begin
         case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
            default:                                f3_ok_s = 1'b0;
         endcase
      end
      // the last accessed byte is the highest, so checking it covers all bytes
      err_s     = !f3_ok_s || ((last_s >> DM_ADDRESS) != 33'd0);
      be8_s     = {4'b0000, mask_s} << off_s;
      wd64_s    = {{DATA_W{1'b0}}, wdata_s} << {off_s, 3'b000};
      split_s   = |be8_s[7:4];
      addr_lo_s = {req_addr[DM_ADDRESS-1:2], 2'b00};
      addr_hi_s = addr_lo_s + {{(DM_ADDRESS-3){1'b0}}, 3'b100};
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state sequencing
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               next_state_s = err_s ? RESP : FIRST;
            end else begin
               next_state_s = IDLE;
            end
         end
         FIRST: begin
            if (split_r) begin
               next_state_s = SECOND;
            end else if (we_r) begin
               next_state_s = RESP;
            end else begin
               next_state_s = WAIT;
            end
         end
         SECOND:  next_state_s = we_r ? RESP : WAIT;
         WAIT:    next_state_s = RESP;
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // latch request fields on acceptance; capture the low word of a split load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_r      <= 1'b0;
         funct3_r  <= 3'b000;
         off_r     <= 2'b00;
         split_r   <= 1'b0;
         addr_hi_r <= {DM_ADDRESS{1'b0}};
         be_hi_r   <= 4'b0000;
         wd_hi_r   <= {DATA_W{1'b0}};
         lo_r      <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         we_r      <= req_we;
         funct3_r  <= req_funct3;
         off_r     <= off_s;
         split_r   <= split_s;
         addr_hi_r <= addr_hi_s;
         be_hi_r   <= be8_s[7:4];
         wd_hi_r   <= wd64_s[2*DATA_W-1:DATA_W];
      end else if (state_r == SECOND && !we_r) begin
         lo_r      <= mem_rd;
      end
   end

   // align the loaded bytes to bit 0 and extend them per funct3
   always_comb begin
      rd64_s = split_r ? {mem_rd, lo_r} : {{DATA_W{1'b0}}, mem_rd};
      sh_s   = DATA_W'(rd64_s >> {off_r, 3'b000});
      case (funct3_r)
         3'b000:  ext_s = {{(DATA_W-8){sh_s[7]}}, sh_s[7:0]};
         3'b001:  ext_s = {{(DATA_W-16){sh_s[15]}}, sh_s[15:0]};
         3'b010:  ext_s = sh_s;
         3'b100:  ext_s = {{(DATA_W-8){1'b0}}, sh_s[7:0]};
         3'b101:  ext_s = {{(DATA_W-16){1'b0}}, sh_s[15:0]};
         default: ext_s = {DATA_W{1'b0}};
      endcase
   end

   // output values for the state being entered (FIRST is only entered from IDLE)
   always_comb begin
      mem_re_n_s     = 1'b0;
      mem_we_n_s     = 1'b0;
      mem_addr_n_s   = {DM_ADDRESS{1'b0}};
      mem_be_n_s     = 4'b0000;
      mem_wd_n_s     = {DATA_W{1'b0}};
      resp_valid_n_s = 1'b0;
      resp_err_n_s   = 1'b0;
      resp_rdata_n_s = {DATA_W{1'b0}};
      case (next_state_s)
         FIRST: begin
            mem_addr_n_s = addr_lo_s;
            if (req_we) begin
               mem_we_n_s = 1'b1;
               mem_be_n_s = be8_s[3:0];
               mem_wd_n_s = wd64_s[DATA_W-1:0];
            end else begin
               mem_re_n_s = 1'b1;
            end
         end
         SECOND: begin
            mem_addr_n_s = addr_hi_r;
            if (we_r) begin
               mem_we_n_s = 1'b1;
               mem_be_n_s = be_hi_r;
               mem_wd_n_s = wd_hi_r;
            end else begin
               mem_re_n_s = 1'b1;
            end
         end
         RESP: begin
            resp_valid_n_s = 1'b1;
            if (state_r == IDLE) begin
               resp_err_n_s = 1'b1;
            end else if (state_r == WAIT) begin
               resp_rdata_n_s = ext_s;
            end else begin
               resp_rdata_n_s = {DATA_W{1'b0}};
            end
         end
         default: begin
            mem_re_n_s = 1'b0;
         end
      endcase
   end

   // registered memory and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= {DM_ADDRESS{1'b0}};
         mem_be     <= 4'b0000;
         mem_wd     <= {DATA_W{1'b0}};
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= {DATA_W{1'b0}};
      end else begin
         mem_re     <= mem_re_n_s;
         mem_we     <= mem_we_n_s;
         mem_addr   <= mem_addr_n_s;
         mem_be     <= mem_be_n_s;
         mem_wd     <= mem_wd_n_s;
         resp_valid <= resp_valid_n_s;
         resp_err   <= resp_err_n_s;
         resp_rdata <= resp_rdata_n_s;
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, meaning data-memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-004 SHALL have reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have req_valid  input  1  pipeline presents a load/store request.
REQ-006 SHALL have req_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have req_funct3  input  3  LB/LH/LW/LBU/LHU or SB/SH/SW encoding.
REQ-009 SHALL have req_addr  input  32  byte address (ALU result).
REQ-010 SHALL have req_wdata  input  DATA_W  store data, right-justified.
REQ-011 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have resp_rdata  output  DATA_W  extended load result; 0 for stores and errors.
REQ-013 SHALL have resp_err  output  1  request rejected, valid with resp_valid.
REQ-014 SHALL have mem_re, mem_we  output  1 each  memory read/write strobes.
REQ-015 SHALL have mem_addr  output  DM_ADDRESS  word-aligned byte address (bits [1:0] = 0).
REQ-016 SHALL have mem_be  output  4  byte-lane write enables.
REQ-017 SHALL have mem_wd  output  DATA_W  lane-aligned write data.
REQ-018 SHALL have mem_rd  input  DATA_W  read word, valid the cycle after mem_re.

Function
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on req_valid & req_ready (cycle N).
REQ-020 SHALL register all mem_* and resp_* outputs; mem_re and mem_we never high together.
REQ-021 SHALL use states IDLE, FIRST, SECOND, WAIT, RESP.
REQ-022 SHALL flag error (no memory access, IDLE->RESP) for illegal funct3 (load 011/110/111, store other than 000/001/010) or any accessed byte at or above 2**DM_ADDRESS.
REQ-023 SHALL treat an access as split when it crosses a word boundary (LH/LHU/SH at offset 3; LW/SW at offset 1-3); byte accesses never split.
REQ-024 Aligned store: IDLE->FIRST issues one write at N+1, RESP pulses resp_valid at N+2.
REQ-025 Split store: FIRST writes low word at N+1, SECOND writes next word at N+2, resp_valid at N+3.
REQ-026 Aligned load: read at N+1, WAIT captures mem_rd at N+2, resp_valid at N+3.
REQ-027 Split load: reads at N+1 and N+2, low word captured N+2, high word N+3, resp_valid at N+4.
REQ-028 SHALL drive mem_be with 1 only in lanes written, shifting req_wdata by byte offset into mem_wd; unused lanes of mem_wd = 0.
REQ-029 SHALL extract loaded bytes from the addressed lanes (little-endian, split bytes concatenated low word first) into resp_rdata LSBs.
REQ-030 SHALL sign-extend for LB/LH, zero-extend for LBU/LHU, pass LW unchanged.
REQ-031 SHALL return from RESP to IDLE after one cycle; resp_valid high exactly one cycle per accepted request.
REQ-032 SHALL ignore req_valid and all req_* inputs outside IDLE; request fields latched at acceptance.
REQ-033 Error response: resp_err=1, resp_rdata=0, resp_valid at N+1.

Reset
REQ-034 SHALL on reset asynchronously enter IDLE and clear req_ready=0 only while reset is high, then req_ready=1 next cycle.
REQ-035 SHALL reset mem_re, mem_we, mem_be, mem_addr, mem_wd, resp_valid, resp_err, resp_rdata to 0.
REQ-036 SHALL abandon any in-flight access on reset mid-operation with no resp_valid for it; a split store interrupted after its first write leaves that write committed.

Verification
REQ-037 SB addr 0x006, wdata 0x000000AB -> N+1: mem_we=1, mem_addr=0x004, mem_be=0100, mem_wd=0x00AB0000; resp_valid N+2, resp_err=0.
REQ-038 LB addr 0x007, mem_rd=0x80112233 -> resp_rdata=0xFFFFFF80 at N+3; LBU same -> 0x00000080.
REQ-039 LW addr 0x00A, mem_rd 0x44332211 (word 0x008) then 0x88776655 (0x00C) -> reads 0x008,0x00C at N+1,N+2; resp_rdata=0x66554433 at N+4.
REQ-040 SW addr 0x1FD -> resp_err=1 at N+1, no mem_we/mem_re ever asserted.
REQ-041 SH addr 0x003 wdata 0x0000BEEF -> N+1 be=1000 wd=0xEF000000 addr 0x000; N+2 be=0001 wd=0x000000BE addr 0x004; resp N+3.
REQ-042 Reset asserted at N+2 of split load -> all outputs 0 immediately, no resp_valid, req_ready=1 first cycle after release.
